fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTRUCTION, default 32'hE000_0000, giving the bubble word inserted on reset/flush.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 The block SHALL have port freeze, input, 1, a hazard stall from decode that holds PC and IF/ID.
REQ-006 The block SHALL have port branch_taken, input, 1, a redirect request from execute.
REQ-007 The block SHALL have port branch_address, input, LEN_ADDRESS, the redirect target.
REQ-008 The block SHALL have port imem_address, output, LEN_ADDRESS, the fetch address driven to instruction memory.
REQ-009 The block SHALL have port imem_instruction, input, LEN_INSTRUCTION, the combinational read data from instruction memory.
REQ-010 The block SHALL have port if_pc, output, LEN_ADDRESS, the registered fetch address + 4 of the instruction held in IF/ID.
REQ-011 The block SHALL have port if_instruction, output, LEN_INSTRUCTION, the registered instruction held in IF/ID.
REQ-012 The block SHALL have port if_valid, output, 1, which is 1 when IF/ID holds a real fetched instruction and 0 for a bubble.

Function
REQ-013 The block SHALL drive imem_address combinationally from the PC register, with zero added latency.
REQ-014 The block SHALL compute next-sequential PC as PC + 4 modulo 2^LEN_ADDRESS (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-015 The block SHALL, on each clock edge, take exactly one action by priority: rst > branch_taken > freeze > advance.
REQ-016 On advance (no rst, no branch_taken, no freeze), the block SHALL load PC <= PC + 4, if_pc <= PC + 4, if_instruction <= imem_instruction and if_valid <= 1.
REQ-017 On freeze without branch_taken, the block SHALL hold PC, if_pc, if_instruction and if_valid unchanged, for any number of cycles.
REQ-018 On branch_taken, the block SHALL load PC <= {branch_address[LEN_ADDRESS-1:2], 2'b00}, if_instruction <= NOP_INSTRUCTION, if_pc <= 0 and if_valid <= 0, irrespective of freeze.
REQ-019 The block SHALL ignore branch_address bits [1:0], so targets are always word-aligned.
REQ-020 The block SHALL make the first fetch from a branch target appear in IF/ID one edge after the flush edge, with if_pc = target + 4.
REQ-021 Back-to-back branch_taken cycles SHALL each redirect, with the last target winning and IF/ID staying a bubble.
REQ-022 The block SHALL have no handshake beyond freeze; imem_instruction SHALL be sampled only on advance edges.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL load PC <= RESET_PC, if_pc <= 0, if_instruction <= NOP_INSTRUCTION and if_valid <= 0.
REQ-024 rst SHALL override branch_taken and freeze when asserted mid-operation, with no state retained.
REQ-025 On the first edge after rst deasserts (no freeze, no branch_taken), the block SHALL fetch from RESET_PC.

Structure
REQ-026 LEN_ADDRESS, LEN_INSTRUCTION and the NOP encoding constant SHALL live in the shared ISA definitions file, with no local redefinition.
REQ-027 The IF/ID pipeline register (if_pc, if_instruction, if_valid, with freeze/flush/rst controls) SHALL be a separate sub-module named if_stage_reg.
REQ-028 The PC register, next-PC adder/mux and priority logic SHALL remain in fetch_stage.

Verification
REQ-029 The bench SHALL cover sequential fetch: reset, then run with memory holding word k at address 4k -> imem_address 0,4,8,12 on successive cycles, and after edge n if_pc=4n, if_instruction=word n-1, if_valid=1.
REQ-030 The bench SHALL cover freeze: freeze=1 for 3 cycles with PC=0x10 -> imem_address stays 0x10, IF/ID outputs unchanged, and after release the next edge gives if_pc=0x14.
REQ-031 The bench SHALL cover branch: branch_taken=1 with branch_address=0x40 while PC=0x14 -> next edge PC=0x40, if_instruction=0xE000_0000, if_valid=0; the following edge gives if_pc=0x44.
REQ-032 The bench SHALL cover simultaneous events: branch_taken=1 and freeze=1 with branch_address=0x43 -> PC=0x40 and IF/ID flushed (branch wins, alignment applied).
REQ-033 The bench SHALL cover reset mid-run: rst=1 together with branch_taken=1 and freeze=1 at PC=0x80 -> PC=RESET_PC, if_valid=0, if_pc=0.
REQ-034 The bench SHALL cover wrap: PC forced via branch to 0xFFFF_FFFC, then advance -> if_pc=0x0000_0000 and PC=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared ISA definitions for the fetch path: word widths, the bubble encoding,
// the IF/ID payload layout and small address helpers.
// Pure declarations; no logic, no latency, no flow control of its own.
package fetch_stage_pkg;

    // Architectural widths used everywhere in the core.
    localparam int LEN_ADDRESS     = 32;
    localparam int LEN_INSTRUCTION = 32;

    // Bubble word placed in IF/ID on reset and on a redirect.
    localparam logic [LEN_INSTRUCTION-1:0] NOP_ENCODING = 32'hE000_0000;

    // Instructions are one word wide, so sequential fetch steps by 4 bytes.
    localparam logic [LEN_ADDRESS-1:0] PC_STEP    = LEN_ADDRESS'(4);
    localparam logic [LEN_ADDRESS-1:0] ALIGN_MASK = ~LEN_ADDRESS'(3);

    typedef logic [LEN_ADDRESS-1:0]     addr_t;
    typedef logic [LEN_INSTRUCTION-1:0] instr_t;

    // The single action taken by the fetch stage on a clock edge.
    typedef enum logic [1:0] {
        ACT_RESET   = 2'd0,
        ACT_FLUSH   = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_ADVANCE = 2'd3
    } fetch_action_t;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        addr_t  pc;
        instr_t instruction;
        logic   valid;
    } if_id_t;

    // Clear the byte-offset bits so every fetch is word aligned.
    function automatic addr_t word_align(input addr_t addr);
        return addr & ALIGN_MASK;
    endfunction

    // Next sequential fetch address; the 32-bit add wraps naturally.
    function automatic addr_t pc_increment(input addr_t addr);
        return addr + PC_STEP;
    endfunction

    // Priority: reset beats redirect beats stall beats normal advance.
    function automatic fetch_action_t select_action(input logic rst,
                                                    input logic branch_taken,
                                                    input logic freeze);
        if (rst)
            return ACT_RESET;
        else if (branch_taken)
            return ACT_FLUSH;
        else if (freeze)
            return ACT_HOLD;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/if_stage_reg.sv
// IF/ID pipeline register: captures fetch address + 4, instruction and valid flag.
// Latency: one clock edge from load inputs to if_* outputs.
// Backpressure: freeze holds contents indefinitely; flush/rst insert a bubble.
// Ports: clk, rst (sync, active-high), flush, freeze, next_pc, instruction in;
//        if_pc, if_instruction, if_valid out.
module if_stage_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [LEN_INSTRUCTION-1:0] NOP_INSTRUCTION = NOP_ENCODING
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       freeze,
    input  logic [LEN_ADDRESS-1:0]     next_pc,
    input  logic [LEN_INSTRUCTION-1:0] instruction,
    output logic [LEN_ADDRESS-1:0]     if_pc,
    output logic [LEN_INSTRUCTION-1:0] if_instruction,
    output logic                       if_valid
);

    if_id_t if_id_q;
    if_id_t bubble;

    // A bubble carries a zero PC so downstream never mistakes it for a real fetch.
    assign bubble = '{pc: '0, instruction: NOP_INSTRUCTION, valid: 1'b0};

    // Flush wins over freeze: a redirect must squash the held instruction
    // even while decode is stalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= bubble;
        end else if (flush) begin
            if_id_q <= bubble;
        end else if (!freeze) begin
            if_id_q <= '{pc: next_pc, instruction: instruction, valid: 1'b1};
        end
    end

    assign if_pc          = if_id_q.pc;
    assign if_instruction = if_id_q.instruction;
    assign if_valid       = if_id_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID register.
// Latency: imem_address is the PC with zero added delay; IF/ID updates one edge later.
// Backpressure: freeze stalls PC and IF/ID; branch_taken redirects and bubbles IF/ID.
// Ports: clk, rst, freeze, branch_taken, branch_address, imem_instruction in;
//        imem_address, if_pc, if_instruction, if_valid out.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [LEN_ADDRESS-1:0]     RESET_PC        = 32'h0000_0000,
    parameter logic [LEN_INSTRUCTION-1:0] NOP_INSTRUCTION = NOP_ENCODING
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [LEN_ADDRESS-1:0]     branch_address,
    output logic [LEN_ADDRESS-1:0]     imem_address,
    input  logic [LEN_INSTRUCTION-1:0] imem_instruction,
    output logic [LEN_ADDRESS-1:0]     if_pc,
    output logic [LEN_INSTRUCTION-1:0] if_instruction,
    output logic                       if_valid
);

    addr_t         pc_q;
    addr_t         pc_d;
    addr_t         pc_seq;
    addr_t         pc_target;
    fetch_action_t action;

    assign action    = select_action(rst, branch_taken, freeze);
    assign pc_seq    = pc_increment(pc_q);
    // Low target bits are dropped so a misaligned redirect still fetches a whole word.
    assign pc_target = word_align(branch_address);

    always_comb begin
        pc_d = pc_q;
        unique case (action)
            ACT_RESET:   pc_d = RESET_PC;
            ACT_FLUSH:   pc_d = pc_target;
            ACT_HOLD:    pc_d = pc_q;
            ACT_ADVANCE: pc_d = pc_seq;
            default:     pc_d = RESET_PC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Instruction memory is read combinationally from the current PC.
    assign imem_address = pc_q;

    // IF/ID records PC + 4 alongside the word read from the current PC.
    if_stage_reg #(
        .NOP_INSTRUCTION (NOP_INSTRUCTION)
    ) u_if_stage_reg (
        .clk            (clk),
        .rst            (rst),
        .flush          (branch_taken),
        .freeze         (freeze),
        .next_pc        (pc_seq),
        .instruction    (imem_instruction),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the spec says PC and IF/ID should hold.
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifi;
    logic        m_ifv;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC        (RESET_PC),
        .NOP_INSTRUCTION (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .branch_taken     (branch_taken),
        .branch_address   (branch_address),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .if_pc            (if_pc),
        .if_instruction   (if_instruction),
        .if_valid         (if_valid)
    );

    // Instruction memory: a distinct word k at every byte address 4k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    always_comb imem_instruction = mem_word(imem_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock edge of the specified behaviour, in priority order.
    task automatic model_edge(input logic r, input logic b, input logic f, input logic [31:0] ba);
        if (r) begin
            m_pc = RESET_PC; m_ifpc = 0; m_ifi = NOP; m_ifv = 1'b0;
        end else if (b) begin
            m_pc = ba - (ba % 4); m_ifpc = 0; m_ifi = NOP; m_ifv = 1'b0;
        end else if (!f) begin
            m_ifi  = mem_word(m_pc);
            m_ifpc = m_pc + 32'd4;
            m_pc   = m_pc + 32'd4;
            m_ifv  = 1'b1;
        end
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, ".imem_address"},   imem_address,   m_pc);
        chk({ctx, ".if_pc"},          if_pc,          m_ifpc);
        chk({ctx, ".if_instruction"}, if_instruction, m_ifi);
        chk({ctx, ".if_valid"},       {31'd0, if_valid}, {31'd0, m_ifv});
    endtask

    // Drive on the falling edge, advance the model at the rising edge, sample 1 ns later.
    task automatic cycle(input logic r, input logic b, input logic f, input logic [31:0] ba,
                         input string ctx);
        @(negedge clk);
        rst = r; branch_taken = b; freeze = f; branch_address = ba;
        @(posedge clk);
        model_edge(r, b, f, ba);
        #1;
        check_model(ctx);
    endtask

    initial begin
        logic        r, b, f;
        logic [31:0] ba;
        logic [31:0] held_instr;

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, "reset");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, "reset");
        chk("reset.pc",    imem_address,   32'h0);
        chk("reset.ifpc",  if_pc,          32'h0);
        chk("reset.instr", if_instruction, NOP);
        chk("reset.valid", {31'd0, if_valid}, 32'd0);

        // Sequential fetch: after edge n, if_pc = 4n and instruction = word n-1.
        for (int n = 1; n <= 4; n++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, "seq");
            chk("seq.pc",    imem_address,   32'(4 * n));
            chk("seq.ifpc",  if_pc,          32'(4 * n));
            chk("seq.instr", if_instruction, mem_word(32'(4 * (n - 1))));
            chk("seq.valid", {31'd0, if_valid}, 32'd1);
        end

        // Freeze three cycles at PC = 0x10.
        held_instr = if_instruction;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0, "freeze");
            chk("freeze.pc",    imem_address,   32'h10);
            chk("freeze.ifpc",  if_pc,          32'h10);
            chk("freeze.instr", if_instruction, held_instr);
            chk("freeze.valid", {31'd0, if_valid}, 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, "unfreeze");
        chk("unfreeze.ifpc",  if_pc,          32'h14);
        chk("unfreeze.instr", if_instruction, mem_word(32'h10));

        // Branch to 0x40 from PC = 0x14.
        chk("pre_branch.pc", imem_address, 32'h14);
        cycle(1'b0, 1'b1, 1'b0, 32'h40, "branch");
        chk("branch.pc",    imem_address,   32'h40);
        chk("branch.instr", if_instruction, NOP);
        chk("branch.valid", {31'd0, if_valid}, 32'd0);
        chk("branch.ifpc",  if_pc,          32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, "post_branch");
        chk("post_branch.ifpc",  if_pc,          32'h44);
        chk("post_branch.instr", if_instruction, mem_word(32'h40));

        // Branch and freeze together, misaligned target.
        cycle(1'b0, 1'b1, 1'b1, 32'h43, "br_frz");
        chk("br_frz.pc",    imem_address, 32'h40);
        chk("br_frz.valid", {31'd0, if_valid}, 32'd0);
        chk("br_frz.instr", if_instruction, NOP);

        // Back-to-back redirects: the last target wins.
        cycle(1'b0, 1'b1, 1'b0, 32'h100, "b2b");
        cycle(1'b0, 1'b1, 1'b0, 32'h206, "b2b");
        chk("b2b.pc",    imem_address, 32'h204);
        chk("b2b.valid", {31'd0, if_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, "b2b_next");
        chk("b2b_next.ifpc", if_pc, 32'h208);

        // Reset mid-run overrides branch and freeze at PC = 0x80.
        cycle(1'b0, 1'b1, 1'b0, 32'h80, "to80");
        cycle(1'b0, 1'b0, 1'b0, 32'h0, "to80");
        cycle(1'b0, 1'b1, 1'b0, 32'h80, "to80");
        chk("mid_rst.pre_pc", imem_address, 32'h80);
        cycle(1'b1, 1'b1, 1'b1, 32'h300, "mid_rst");
        chk("mid_rst.pc",    imem_address, RESET_PC);
        chk("mid_rst.valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst.ifpc",  if_pc, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, "after_rst");
        chk("after_rst.ifpc",  if_pc, RESET_PC + 32'd4);
        chk("after_rst.instr", if_instruction, mem_word(RESET_PC));

        // Wrap at the top of the address space.
        cycle(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, "wrap");
        chk("wrap.pc_top", imem_address, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, "wrap");
        chk("wrap.ifpc",  if_pc,          32'h0000_0000);
        chk("wrap.pc",    imem_address,   32'h0000_0000);
        chk("wrap.instr", if_instruction, mem_word(32'hFFFF_FFFC));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 31) == 0);
            b = ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                ba = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else
                ba = $urandom;
            cycle(r, b, f, ba, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
